// File: rtl/bus_slave_pkg.sv
// Shared types and helpers for the bus_slave_regfile slice.
package bus_slave_pkg;

  // Transaction FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10,
    HOLD = 2'b11
  } state_t;

  // Response decided at request accept, issued in RESP.
  typedef enum logic [1:0] {
    RSP_NONE = 2'b00,
    RSP_ACK  = 2'b01,
    RSP_ERR  = 2'b10
  } resp_t;

  // ID register layout: slave_address in the top DEV_WIDTH bits,
  // register count in the low byte, zero in between.
  localparam int unsigned ID_COUNT_LSB  = 0;
  localparam int unsigned ID_COUNT_BITS = 8;

  // Wait-state counter width (WAIT_STATES is 0..15).
  localparam int unsigned WAIT_CTR_WIDTH = 4;

  // Byte-strobe merge: take the new byte when its strobe is set.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       strobe);
    return strobe ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/bus_slave_wait_ctr.sv
// Loadable down-counter; done is high while the count is zero.
module bus_slave_wait_ctr
  import bus_slave_pkg::*;
#(
  parameter int unsigned WIDTH = WAIT_CTR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Load on request, otherwise count down and stick at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/bus_slave_regfile.sv
// Addressed register-file slave on the request/acknowledge bus.
// Optional read-only ID register at index 0: define BUS_SLAVE_RO_ID_EN.
module bus_slave_regfile
  import bus_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEV_WIDTH   = 8,
  parameter int unsigned IDX_WIDTH   = 3,
  parameter int unsigned NUM_REGS    = 6,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DEV_WIDTH-1:0]          slave_address,
  input  logic                          req,
  input  logic                          we,
  input  logic [DEV_WIDTH+IDX_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH/8-1:0]       be,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          ack,
  output logic                          err,
  output logic                          busy
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
`ifdef BUS_SLAVE_RO_ID_EN
  localparam int unsigned FIRST_REG = 1;
`else
  localparam int unsigned FIRST_REG = 0;
`endif
  localparam logic [WAIT_CTR_WIDTH-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WAIT_CTR_WIDTH'(WAIT_STATES - 1) : '0;

  state_t                  state, state_next;
  resp_t                   rsp_q;
  logic                    we_q;
  logic [IDX_WIDTH-1:0]    idx_q;
  logic [NUM_BYTES-1:0]    be_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   regs [FIRST_REG:NUM_REGS-1];
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [IDX_WIDTH-1:0]    idx;
  logic                    hit, accept, req_err, wait_done;

  assign idx    = addr[IDX_WIDTH-1:0];
  assign hit    = req && (addr[DEV_WIDTH+IDX_WIDTH-1:IDX_WIDTH] == slave_address);
  assign accept = (state == IDLE) && hit;

  // Classify the incoming request as ack or err.
  always_comb begin
    req_err = (32'(idx) >= NUM_REGS);
`ifdef BUS_SLAVE_RO_ID_EN
    if (we && (idx == '0)) req_err = 1'b1;
`endif
  end

  bus_slave_wait_ctr #(
    .WIDTH(WAIT_CTR_WIDTH)
  ) u_wait_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .load_value(WAIT_LOAD),
    .done      (wait_done)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; HOLD blocks a held req from re-triggering.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (hit) state_next = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT: if (wait_done) state_next = RESP;
      RESP: state_next = HOLD;
      HOLD: if (!req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the request when it is accepted from IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rsp_q   <= RSP_NONE;
    end else if (accept) begin
      we_q    <= we;
      idx_q   <= idx;
      be_q    <= be;
      wdata_q <= wdata;
      rsp_q   <= req_err ? RSP_ERR : RSP_ACK;
    end
  end

  // Register storage; writes commit on the edge that ends RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = FIRST_REG; i < NUM_REGS; i++) regs[i] <= '0;
    end else if ((state == RESP) && (rsp_q == RSP_ACK) && we_q) begin
      for (int unsigned i = FIRST_REG; i < NUM_REGS; i++) begin
        if (32'(idx_q) == i) begin
          for (int unsigned b = 0; b < NUM_BYTES; b++) begin
            regs[i][8*b +: 8] <= merge_byte(regs[i][8*b +: 8], wdata_q[8*b +: 8], be_q[b]);
          end
        end
      end
    end
  end

`ifdef BUS_SLAVE_RO_ID_EN
  logic [DATA_WIDTH-1:0] id_word;

  // Read-only ID word built from the strap and register count.
  always_comb begin
    id_word = '0;
    id_word[DATA_WIDTH-1 -: DEV_WIDTH] = slave_address;
    id_word[ID_COUNT_LSB +: ID_COUNT_BITS] = ID_COUNT_BITS'(NUM_REGS);
  end
`endif

  // Read mux over the latched index.
  always_comb begin
    rd_word = '0;
`ifdef BUS_SLAVE_RO_ID_EN
    if (idx_q == '0) rd_word = id_word;
`endif
    for (int unsigned i = FIRST_REG; i < NUM_REGS; i++) begin
      if (32'(idx_q) == i) rd_word = regs[i];
    end
  end

  assign ack   = (state == RESP) && (rsp_q == RSP_ACK);
  assign err   = (state == RESP) && (rsp_q == RSP_ERR);
  assign rdata = (ack && !we_q) ? rd_word : '0;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_bus_slave_regfile.sv
// Directed bench for bus_slave_regfile: two slaves (A5, B2) on one bus,
// scoreboard queue of expected responses, reference register model.
module tb_bus_slave_regfile;

  localparam int EXP_LAT = 2;  // 1 + WAIT_STATES

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [10:0] addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata_a, rdata_b;
  logic        ack_a, err_a, busy_a, ack_b, err_b, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        ack_a, err_a, ack_b, err_b;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [2][8];

  always #5 clk = ~clk;

  bus_slave_regfile #(.DATA_WIDTH(32), .DEV_WIDTH(8), .IDX_WIDTH(3),
                      .NUM_REGS(6), .WAIT_STATES(1)) u_a (
    .clk(clk), .reset(reset), .slave_address(8'hA5), .req(req), .we(we),
    .addr(addr), .be(be), .wdata(wdata), .rdata(rdata_a), .ack(ack_a),
    .err(err_a), .busy(busy_a));

  bus_slave_regfile #(.DATA_WIDTH(32), .DEV_WIDTH(8), .IDX_WIDTH(3),
                      .NUM_REGS(6), .WAIT_STATES(1)) u_b (
    .clk(clk), .reset(reset), .slave_address(8'hB2), .req(req), .we(we),
    .addr(addr), .be(be), .wdata(wdata), .rdata(rdata_b), .ack(ack_b),
    .err(err_b), .busy(busy_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge_model(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] read_model(int sl, logic [7:0] dev, logic [2:0] idx);
`ifdef BUS_SLAVE_RO_ID_EN
    if (idx == 3'd0) return {dev, 16'h0000, 8'h06};
`endif
    return model[sl][idx];
  endfunction

  task automatic clear_model();
    for (int unsigned s = 0; s < 2; s++)
      for (int unsigned i = 0; i < 8; i++) model[s][i] = '0;
  endtask

  // One transaction to slave A5 or B2; expected result queued before driving.
  task automatic xact(input logic w, input logic [7:0] dev, input logic [2:0] idx,
                      input logic [3:0] s, input logic [31:0] d);
    exp_t e, got_e;
    int   sl, lat;
    logic perr, got;
    sl   = (dev == 8'hB2) ? 1 : 0;
    perr = (idx >= 3'd6);
`ifdef BUS_SLAVE_RO_ID_EN
    if (w && idx == 3'd0) perr = 1'b1;
`endif
    e.rdata = (!w && !perr) ? read_model(sl, dev, idx) : 32'h0;
    e.ack_a = (sl == 0) && !perr;
    e.err_a = (sl == 0) && perr;
    e.ack_b = (sl == 1) && !perr;
    e.err_b = (sl == 1) && perr;
    if (w && !perr) model[sl][idx] = merge_model(model[sl][idx], d, s);
    sb.push_back(e);

    @(negedge clk);
    req = 1'b1; we = w; addr = {dev, idx}; be = s; wdata = d;
    got = 1'b0; lat = 0;
    for (int unsigned c = 1; c <= 16 && !got; c++) begin
      @(negedge clk);
      if (ack_a | ack_b | err_a | err_b) begin got = 1'b1; lat = c; end
    end
    chk("resp_seen", got, 1'b1);
    got_e = sb.pop_front();
    chk("latency", lat, EXP_LAT);
    chk("ack_a", ack_a, got_e.ack_a);
    chk("err_a", err_a, got_e.err_a);
    chk("ack_b", ack_b, got_e.ack_b);
    chk("err_b", err_b, got_e.err_b);
    chk("rdata", rdata_a | rdata_b, got_e.rdata);
    req = 1'b0;
    @(negedge clk);
    chk("pulse_end", {ack_a, err_a, ack_b, err_b}, 4'b0000);
    chk("rdata_idle", rdata_a | rdata_b, 32'h0);
    @(negedge clk);
    chk("busy_idle", {busy_a, busy_b}, 2'b00);
  endtask

  initial begin
    clear_model();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {busy_a, busy_b}, 2'b00);
    chk("rst_resp", {ack_a, err_a, ack_b, err_b}, 4'b0000);
    chk("rst_rdata", rdata_a | rdata_b, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Write then read
    xact(1'b1, 8'hA5, 3'd2, 4'hF, 32'hDEADBEEF);
    xact(1'b0, 8'hA5, 3'd2, 4'h0, 32'h0);

    // Byte strobes
    xact(1'b1, 8'hA5, 3'd3, 4'hF, 32'h11223344);
    xact(1'b1, 8'hA5, 3'd3, 4'b0101, 32'hAABBCCDD);
    xact(1'b0, 8'hA5, 3'd3, 4'h0, 32'h0);
    chk("strobe_model", model[0][3], 32'h11BB33DD);

    // be = 0 is a no-op that still acks
    xact(1'b1, 8'hA5, 3'd2, 4'h0, 32'h01234567);
    xact(1'b0, 8'hA5, 3'd2, 4'h0, 32'h0);

    // Out of range
    xact(1'b0, 8'hA5, 3'd7, 4'h0, 32'h0);
    xact(1'b1, 8'hA5, 3'd6, 4'hF, 32'hFFFFFFFF);
    for (int unsigned i = 0; i < 6; i++) xact(1'b0, 8'hA5, 3'(i), 4'h0, 32'h0);

    // Second slave, and an unclaimed address
    xact(1'b1, 8'hB2, 3'd1, 4'hF, 32'hCAFEF00D);
    xact(1'b0, 8'hB2, 3'd1, 4'h0, 32'h0);
    xact(1'b0, 8'hA5, 3'd1, 4'h0, 32'h0);
    begin
      logic seen;
      seen = 1'b0;
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = {8'hC0, 3'd1}; be = 4'hF; wdata = 32'h5A5A5A5A;
      repeat (6) begin
        @(negedge clk);
        if (ack_a | ack_b | err_a | err_b | busy_a | busy_b) seen = 1'b1;
      end
      req = 1'b0;
      chk("miss_quiet", seen, 1'b0);
    end

    // Held req gives exactly one ack
    begin
      int acks;
      acks = 0;
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = {8'hA5, 3'd2}; be = 4'h0;
      repeat (6) begin
        @(negedge clk);
        if (ack_a) acks++;
      end
      req = 1'b0;
      chk("held_acks", acks, 1);
      repeat (2) @(negedge clk);
      chk("held_idle", busy_a, 1'b0);
    end

    // Index 0 behaviour
`ifdef BUS_SLAVE_RO_ID_EN
    xact(1'b0, 8'hA5, 3'd0, 4'h0, 32'h0);
    chk("id_model", read_model(0, 8'hA5, 3'd0), 32'hA5000006);
    xact(1'b1, 8'hA5, 3'd0, 4'hF, 32'h12345678);
    xact(1'b0, 8'hA5, 3'd0, 4'h0, 32'h0);
`else
    xact(1'b1, 8'hA5, 3'd0, 4'hF, 32'h12345678);
    xact(1'b0, 8'hA5, 3'd0, 4'h0, 32'h0);
`endif

    // Reset during WAIT aborts the write
    begin
      int acks;
      acks = 0;
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = {8'hA5, 3'd4}; be = 4'hF; wdata = 32'h87654321;
      @(negedge clk);
      chk("wait_busy", busy_a, 1'b1);
      #1 reset = 1'b0;
      #1 chk("rst_busy_async", busy_a, 1'b0);
      repeat (3) begin
        @(negedge clk);
        if (ack_a | err_a) acks++;
      end
      req = 1'b0;
      reset = 1'b1;
      chk("rst_no_ack", acks, 0);
      clear_model();
    end
    xact(1'b0, 8'hA5, 3'd4, 4'h0, 32'h0);
    xact(1'b0, 8'hA5, 3'd2, 4'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_slave_regfile.md
Name: bus_slave_regfile

Overview:
- Parametrised successor to the fixed-width bus slave: an addressed register-file slave on the shared request/acknowledge bus.
- Serves single-beat reads and writes to NUM_REGS registers with byte strobes, programmable wait states and an error response.
- Sits behind the bus master alongside other slaves; the upper address bits are compared against the strap input slave_address.

Parameters:
- DATA_WIDTH, 32, data bus width; must be a multiple of 8.
- DEV_WIDTH, 8, width of the device-select field and of slave_address.
- IDX_WIDTH, 3, width of the register-index field.
- NUM_REGS, 6, implemented registers; 1 <= NUM_REGS <= 2**IDX_WIDTH.
- WAIT_STATES, 1, cycles inserted between request accept and ack; 0..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- slave_address  in  DEV_WIDTH  static device address strap.
- req  in  1  master request; held high until ack or err.
- we  in  1  1 = write, 0 = read; stable while req is high.
- addr  in  DEV_WIDTH+IDX_WIDTH  {device, index}; stable while req is high.
- be  in  DATA_WIDTH/8  byte write strobes.
- wdata  in  DATA_WIDTH  write data.
- rdata  out  DATA_WIDTH  read data; all zero when not responding.
- ack  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse; mutually exclusive with ack.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - all registers and rdata = 0, ack = err = busy = 0, FSM = IDLE.
  - Reset mid-transaction aborts it with no register update.
- Select: hit = req && addr[DEV_WIDTH+IDX_WIDTH-1:IDX_WIDTH] == slave_address. Non-hit requests are ignored entirely; the slave drives nothing non-zero.
- FSM IDLE -> WAIT -> RESP -> HOLD -> IDLE.
  - IDLE: on hit, latch we/idx/be/wdata. Go to WAIT if WAIT_STATES > 0, else RESP.
  - WAIT: counter loads WAIT_STATES-1 and decrements; at 0 go to RESP.
  - RESP: assert exactly one of ack or err for one cycle. Writes commit on this edge. rdata is valid only in this cycle, zero otherwise.
  - HOLD: wait for req low, then go to IDLE. This prevents a held req from re-triggering.
- Latency: req rises at edge N; ack/err is high in cycle N+1+WAIT_STATES.
- Write: for each byte b with be[b] = 1, reg[idx][8b+7:8b] = wdata byte b; other bytes are kept. be = 0 is a legal no-op and returns ack.
- Error: idx >= NUM_REGS -> err. The write is dropped; a read returns rdata = 0.
- req dropping in WAIT: transaction continues; the response is still issued and the FSM then returns via HOLD.
- Back-to-back requests: a new request is accepted only from IDLE, so the minimum spacing is 1 idle cycle of req low.
- Multiple slaves sharing the bus are resolved by OR of rdata/ack/err; zero-when-idle is therefore mandatory.

Optional Feature:
- Macro BUS_SLAVE_RO_ID_EN.
- When defined:
  - Index 0 is a read-only ID register returning {slave_address, zero-pad, NUM_REGS[7:0]} zero-extended to DATA_WIDTH.
  - Writes to index 0 give err and have no effect.
  - Storage exists only for indices 1..NUM_REGS-1.
- When undefined: index 0 is an ordinary read/write register.

Decomposition:
- Package bus_slave_pkg holds:
  - the FSM state enum (IDLE, WAIT, RESP, HOLD);
  - the response encoding;
  - the ID-register layout constant;
  - a function for byte-strobe merging.
- One sub-module, bus_slave_wait_ctr: loadable down-counter that outputs a done flag, used for the wait states.

Test Plan:
- Write then read, with slave_address = 8'hA5, WAIT_STATES = 1:
  - Write addr {A5,3'd2}, be = 4'hF, wdata = 32'hDEADBEEF -> ack 2 cycles after req.
  - Read of the same address -> rdata = 32'hDEADBEEF with ack.
- Byte strobes: reg 3 = 32'h11223344, then write be = 4'b0101, wdata = 32'hAABBCCDD -> read returns 32'h11BB33DD.
- Out of range: NUM_REGS = 6, read index 7 -> err pulse, rdata = 0, no ack. A write to index 6 leaves regs 0..5 unchanged.
- Two instances at A5 and B2: write to {B2,1} changes only slave B2. A request to 8'hC0 produces no ack/err and busy stays 0 in both.
- Held req / reset:
  - req held high for 6 cycles -> exactly one ack.
  - reset pulled low during WAIT -> ack never fires, target register stays 0, busy = 0 immediately.
- With BUS_SLAVE_RO_ID_EN defined: read index 0 at slave A5 -> 32'hA5000006. Write index 0 -> err, and a following read is unchanged.
